reg_access_bridge: RTL and testbench
====================================

REG_ACCESS_BRIDGE -- requirements
Module: reg_access_bridge

Interface
REQ-001 SHALL have parameters: DATA_WIDTH, default 32, register data width; ADDR_WIDTH, default 4, register address width.
REQ-002 SHALL have ports:
- clk  in  1  sole clock, all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- host_req_valid  in  1  host request present.
- host_req_ready  out  1  bridge can accept a request.
- host_req_write  in  1  1 = write, 0 = read.
- host_req_addr  in  ADDR_WIDTH  target register.
- host_req_wdata  in  DATA_WIDTH  write data.
- host_resp_valid  out  1  response present.
- host_resp_ready  in  1  host accepts response.
- host_resp_write  out  1  echoes the request type.
- host_resp_rdata  out  DATA_WIDTH  read data; 0 for writes.
- core_write_enable  in  1  core requests register file write port.
- core_write_addr  in  ADDR_WIDTH  core write address.
- core_write_data  in  DATA_WIDTH  core write data.
- rf_write_enable  out  1  register file write strobe.
- rf_write_addr  out  ADDR_WIDTH  register file write address.
- rf_write_data  out  DATA_WIDTH  register file write data.
- rf_read_addr  out  ADDR_WIDTH  register file read port address (registered).
- rf_read_data  in  DATA_WIDTH  register file read data, valid one cycle after rf_read_addr.
- stall_count  out  8  cycles a host write was blocked by the core.

Function
REQ-003 SHALL implement FSM states IDLE, WRITE, RD_ISSUE, RD_CAPTURE, RESP.
REQ-004 host_req_ready SHALL be 1 only in IDLE with reset low.
REQ-005 IDLE: on host_req_valid & host_req_ready SHALL capture write/addr/wdata into request registers; next state WRITE if write, else RD_ISSUE.
REQ-006 Write port mux SHALL be combinational: core_write_enable=1 -> rf_write_* = core_write_*; else in WRITE -> host captured addr/data with rf_write_enable=1; else rf_write_enable=0.
REQ-007 Core SHALL always have priority; the core write path SHALL never be delayed by the bridge.
REQ-008 WRITE: if core_write_enable=1, remain in WRITE and increment stall_count, saturating at 255; else perform host write this cycle, next state RESP.
REQ-009 RD_ISSUE: rf_read_addr SHALL hold captured address from this cycle through RD_CAPTURE; next state RD_CAPTURE.
REQ-010 RD_CAPTURE: SHALL register rf_read_data into response data; next state RESP.
REQ-011 Bypass: if in RD_ISSUE or RD_CAPTURE a core write hits the captured address, response data SHALL be the last such core_write_data, not rf_read_data.
REQ-012 RESP: host_resp_valid=1, host_resp_write and host_resp_rdata stable; on host_resp_ready next state IDLE; SHALL hold indefinitely otherwise.
REQ-013 Latency from acceptance edge T, no contention, resp_ready high: write -> rf_write_enable at T+1, host_resp_valid at T+2; read -> rf_read_addr valid at T+1, host_resp_valid at T+3.
REQ-014 At most one request outstanding; no new request accepted before the response handshake completes.
REQ-015 host_resp_rdata SHALL be 0 for write responses.

Reset
REQ-016 With reset high at a rising edge: state IDLE; host_resp_valid, host_resp_write, host_resp_rdata, rf_read_addr, stall_count, request registers all 0.
REQ-017 host_req_ready SHALL be 0 while reset is high.
REQ-018 Reset mid-operation SHALL abandon the request: no host write, no response afterwards.
REQ-019 Core write passthrough SHALL remain functional during reset.

Verification
REQ-020 Host write addr 3, data 0xDEADBEEF, no core traffic -> rf_write_enable 1 one cycle at T+1 with addr 3, data 0xDEADBEEF; resp_valid T+2, resp_write 1, rdata 0.
REQ-021 Host read addr 5, rf_read_data model returns 0x12345678 -> rf_read_addr 5 at T+1; resp_valid T+3, rdata 0x12345678.
REQ-022 Host write addr 2 with core_write_enable held 3 cycles from T+1 -> core writes pass unchanged; host write at T+4; stall_count 3.
REQ-023 Host read addr 7, core writes addr 7 data 0xA5A5A5A5 in RD_ISSUE -> rdata 0xA5A5A5A5.
REQ-024 host_resp_ready low 10 cycles -> resp_valid and rdata held, host_req_ready 0; then one handshake, return to IDLE.
REQ-025 Reset asserted in WRITE while core stalls -> no host write ever issued, no response, stall_count 0, host_req_ready 1 one cycle after reset deasserts.

Source files
------------

// File: rtl/reg_access_bridge.sv
// Host-to-register-file bridge: one outstanding host request, core owns the write port.
// Handshakes: a transfer happens on a rising edge where valid & ready are both high;
// valid is held with its payload stable until that edge and is never gated by ready.
module reg_access_bridge #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  host_req_valid,
  output logic                  host_req_ready,
  input  logic                  host_req_write,
  input  logic [ADDR_WIDTH-1:0] host_req_addr,
  input  logic [DATA_WIDTH-1:0] host_req_wdata,
  output logic                  host_resp_valid,
  input  logic                  host_resp_ready,
  output logic                  host_resp_write,
  output logic [DATA_WIDTH-1:0] host_resp_rdata,
  input  logic                  core_write_enable,
  input  logic [ADDR_WIDTH-1:0] core_write_addr,
  input  logic [DATA_WIDTH-1:0] core_write_data,
  output logic                  rf_write_enable,
  output logic [ADDR_WIDTH-1:0] rf_write_addr,
  output logic [DATA_WIDTH-1:0] rf_write_data,
  output logic [ADDR_WIDTH-1:0] rf_read_addr,
  input  logic [DATA_WIDTH-1:0] rf_read_data,
  output logic [7:0]            stall_count,
  output logic [2:0]            o_dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_WRITE      = 3'd1,
    S_RD_ISSUE   = 3'd2,
    S_RD_CAPTURE = 3'd3,
    S_RESP       = 3'd4
  } state_t;

  state_t                r_state;
  logic                  r_req_write;
  logic [ADDR_WIDTH-1:0] r_req_addr;
  logic [DATA_WIDTH-1:0] r_req_wdata;
  logic                  r_resp_valid;
  logic                  r_resp_write;
  logic [DATA_WIDTH-1:0] r_resp_rdata;
  logic [ADDR_WIDTH-1:0] r_read_addr;
  logic [7:0]            r_stall_count;
  logic                  r_byp_hit;
  logic [DATA_WIDTH-1:0] r_byp_data;

  logic w_accept;
  logic w_core_hit;

  assign host_req_ready  = (r_state == S_IDLE) && !reset;
  assign w_accept        = host_req_valid && host_req_ready;
  assign w_core_hit      = core_write_enable && (core_write_addr == r_req_addr);

  assign host_resp_valid = r_resp_valid;
  assign host_resp_write = r_resp_write;
  assign host_resp_rdata = r_resp_rdata;
  assign rf_read_addr    = r_read_addr;
  assign stall_count     = r_stall_count;
  assign o_dbg_state     = r_state;

  // Core traffic goes straight through, even in reset; the host only gets leftover cycles.
  always_comb begin
    rf_write_enable = 1'b0;
    rf_write_addr   = '0;
    rf_write_data   = '0;
    if (core_write_enable) begin
      rf_write_enable = 1'b1;
      rf_write_addr   = core_write_addr;
      rf_write_data   = core_write_data;
    end else if (r_state == S_WRITE) begin
      rf_write_enable = 1'b1;
      rf_write_addr   = r_req_addr;
      rf_write_data   = r_req_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_req_write   <= 1'b0;
      r_req_addr    <= '0;
      r_req_wdata   <= '0;
      r_resp_valid  <= 1'b0;
      r_resp_write  <= 1'b0;
      r_resp_rdata  <= '0;
      r_read_addr   <= '0;
      r_stall_count <= '0;
      r_byp_hit     <= 1'b0;
      r_byp_data    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_byp_hit <= 1'b0;
          if (w_accept) begin
            r_req_write <= host_req_write;
            r_req_addr  <= host_req_addr;
            r_req_wdata <= host_req_wdata;
            if (host_req_write) begin
              r_state <= S_WRITE;
            end else begin
              r_read_addr <= host_req_addr;
              r_state     <= S_RD_ISSUE;
            end
          end
        end
        S_WRITE: begin
          if (core_write_enable) begin
            if (r_stall_count != 8'hFF) r_stall_count <= r_stall_count + 8'd1;
          end else begin
            r_resp_valid <= 1'b1;
            r_resp_write <= 1'b1;
            r_resp_rdata <= '0;
            r_state      <= S_RESP;
          end
        end
        S_RD_ISSUE: begin
          // The register file read is already in flight, so a colliding core write is remembered.
          if (w_core_hit) begin
            r_byp_hit  <= 1'b1;
            r_byp_data <= core_write_data;
          end
          r_state <= S_RD_CAPTURE;
        end
        S_RD_CAPTURE: begin
          r_resp_valid <= 1'b1;
          r_resp_write <= 1'b0;
          if (w_core_hit)     r_resp_rdata <= core_write_data;
          else if (r_byp_hit) r_resp_rdata <= r_byp_data;
          else                r_resp_rdata <= rf_read_data;
          r_state <= S_RESP;
        end
        S_RESP: begin
          if (host_resp_ready) begin
            r_resp_valid <= 1'b0;
            r_state      <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_access_bridge.sv
// Directed bench for reg_access_bridge; the register file is a read-only lookup model.
module tb_reg_access_bridge;

  logic        clk;
  logic        reset;
  logic        host_req_valid;
  logic        host_req_ready;
  logic        host_req_write;
  logic [3:0]  host_req_addr;
  logic [31:0] host_req_wdata;
  logic        host_resp_valid;
  logic        host_resp_ready;
  logic        host_resp_write;
  logic [31:0] host_resp_rdata;
  logic        core_write_enable;
  logic [3:0]  core_write_addr;
  logic [31:0] core_write_data;
  logic        rf_write_enable;
  logic [3:0]  rf_write_addr;
  logic [31:0] rf_write_data;
  logic [3:0]  rf_read_addr;
  logic [31:0] rf_read_data;
  logic [7:0]  stall_count;
  logic [2:0]  dbg_state;

  int n_checks;
  int n_fail;
  int host_wr_count;

  reg_access_bridge #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) dut (
    .clk               (clk),
    .reset             (reset),
    .host_req_valid    (host_req_valid),
    .host_req_ready    (host_req_ready),
    .host_req_write    (host_req_write),
    .host_req_addr     (host_req_addr),
    .host_req_wdata    (host_req_wdata),
    .host_resp_valid   (host_resp_valid),
    .host_resp_ready   (host_resp_ready),
    .host_resp_write   (host_resp_write),
    .host_resp_rdata   (host_resp_rdata),
    .core_write_enable (core_write_enable),
    .core_write_addr   (core_write_addr),
    .core_write_data   (core_write_data),
    .rf_write_enable   (rf_write_enable),
    .rf_write_addr     (rf_write_addr),
    .rf_write_data     (rf_write_data),
    .rf_read_addr      (rf_read_addr),
    .rf_read_data      (rf_read_data),
    .stall_count       (stall_count),
    .o_dbg_state       (dbg_state)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rf_model(input logic [3:0] a);
    return (a == 4'd5) ? 32'h1234_5678 : {28'hC0FFEE0, a};
  endfunction

  // Registered read port plus a count of writes the bridge itself originated.
  always @(posedge clk) begin
    rf_read_data <= rf_model(rf_read_addr);
    if (rf_write_enable && !core_write_enable) host_wr_count <= host_wr_count + 1;
  end

  // Driver: present a request; returns at acceptance edge T plus 1ns.
  task automatic drive_req(input logic w, input logic [3:0] a, input logic [31:0] d);
    host_req_valid = 1'b1;
    host_req_write = w;
    host_req_addr  = a;
    host_req_wdata = d;
    @(posedge clk); #1;
    host_req_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    core_write_enable = 1'b1; core_write_addr = 4'hA; core_write_data = 32'hCAFE_0001;
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_checks++; if (host_req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b expected 0", host_req_ready); end
    n_checks++; if (host_resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid: got %b expected 0", host_resp_valid); end
    n_checks++; if (host_resp_write !== 1'b0) begin n_fail++; $display("FAIL reset_resp_write: got %b expected 0", host_resp_write); end
    n_checks++; if (host_resp_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h expected 0", host_resp_rdata); end
    n_checks++; if (rf_read_addr !== 4'h0) begin n_fail++; $display("FAIL reset_rd_addr: got %h expected 0", rf_read_addr); end
    n_checks++; if (stall_count !== 8'h0) begin n_fail++; $display("FAIL reset_stall: got %0d expected 0", stall_count); end
    n_checks++; if (dbg_state !== 3'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", dbg_state); end
    n_checks++; if ({rf_write_enable, rf_write_addr, rf_write_data} !== {1'b1, 4'hA, 32'hCAFE_0001}) begin
      n_fail++; $display("FAIL reset_core_pass: got %b %h %h expected 1 a cafe0001", rf_write_enable, rf_write_addr, rf_write_data);
    end
    core_write_enable = 1'b0;
    reset = 1'b0;
    #1;
    n_checks++; if (host_req_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_ready: got %b expected 1", host_req_ready); end
    n_checks++; if (rf_write_enable !== 1'b0) begin n_fail++; $display("FAIL post_reset_we: got %b expected 0", rf_write_enable); end
  endtask

  task automatic test_write();
    int wr0;
    wr0 = host_wr_count;
    drive_req(1'b1, 4'd3, 32'hDEAD_BEEF);
    n_checks++; if ({rf_write_enable, rf_write_addr, rf_write_data} !== {1'b1, 4'd3, 32'hDEAD_BEEF}) begin
      n_fail++; $display("FAIL write_port_t1: got %b %h %h expected 1 3 deadbeef", rf_write_enable, rf_write_addr, rf_write_data);
    end
    n_checks++; if (host_resp_valid !== 1'b0) begin n_fail++; $display("FAIL write_resp_early: got %b expected 0", host_resp_valid); end
    n_checks++; if (host_req_ready !== 1'b0) begin n_fail++; $display("FAIL write_busy_ready: got %b expected 0", host_req_ready); end
    @(posedge clk); #1;
    n_checks++; if (rf_write_enable !== 1'b0) begin n_fail++; $display("FAIL write_one_cycle: got %b expected 0", rf_write_enable); end
    n_checks++; if ({host_resp_valid, host_resp_write, host_resp_rdata} !== {1'b1, 1'b1, 32'h0}) begin
      n_fail++; $display("FAIL write_resp_t2: got %b %b %h expected 1 1 0", host_resp_valid, host_resp_write, host_resp_rdata);
    end
    @(posedge clk); #1;
    n_checks++; if ({host_resp_valid, host_req_ready} !== 2'b01) begin
      n_fail++; $display("FAIL write_done: got valid %b ready %b expected 0 1", host_resp_valid, host_req_ready);
    end
    n_checks++; if (host_wr_count - wr0 !== 1) begin n_fail++; $display("FAIL write_count: got %0d expected 1", host_wr_count - wr0); end
  endtask

  task automatic test_read();
    drive_req(1'b0, 4'd5, 32'h0);
    n_checks++; if (rf_read_addr !== 4'd5) begin n_fail++; $display("FAIL read_addr_t1: got %h expected 5", rf_read_addr); end
    n_checks++; if (rf_write_enable !== 1'b0) begin n_fail++; $display("FAIL read_no_write: got %b expected 0", rf_write_enable); end
    @(posedge clk); #1;
    n_checks++; if ({host_resp_valid, rf_read_addr} !== {1'b0, 4'd5}) begin
      n_fail++; $display("FAIL read_t2: got valid %b addr %h expected 0 5", host_resp_valid, rf_read_addr);
    end
    @(posedge clk); #1;
    n_checks++; if ({host_resp_valid, host_resp_write, host_resp_rdata} !== {1'b1, 1'b0, 32'h1234_5678}) begin
      n_fail++; $display("FAIL read_resp_t3: got %b %b %h expected 1 0 12345678", host_resp_valid, host_resp_write, host_resp_rdata);
    end
    @(posedge clk); #1;
    n_checks++; if (host_resp_valid !== 1'b0) begin n_fail++; $display("FAIL read_done: got %b expected 0", host_resp_valid); end
  endtask

  task automatic test_stall();
    logic [31:0] cd;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    drive_req(1'b1, 4'd2, 32'h1111_2222);
    for (int k = 0; k < 3; k++) begin
      cd = 32'hC000_0000 + k;
      core_write_enable = 1'b1; core_write_addr = 4'd9 + k[3:0]; core_write_data = cd;
      #1;
      n_checks++; if ({rf_write_enable, rf_write_addr, rf_write_data} !== {1'b1, 4'd9 + k[3:0], cd}) begin
        n_fail++; $display("FAIL stall_core_pass%0d: got %b %h %h expected 1 %h %h", k, rf_write_enable, rf_write_addr, rf_write_data, 4'd9 + k[3:0], cd);
      end
      @(posedge clk); #1;
    end
    core_write_enable = 1'b0;
    #1;
    n_checks++; if ({rf_write_enable, rf_write_addr, rf_write_data} !== {1'b1, 4'd2, 32'h1111_2222}) begin
      n_fail++; $display("FAIL stall_host_t4: got %b %h %h expected 1 2 11112222", rf_write_enable, rf_write_addr, rf_write_data);
    end
    n_checks++; if (stall_count !== 8'd3) begin n_fail++; $display("FAIL stall_count: got %0d expected 3", stall_count); end
    n_checks++; if (dbg_state !== 3'd1) begin n_fail++; $display("FAIL stall_state: got %0d expected 1", dbg_state); end
    @(posedge clk); #1;
    n_checks++; if ({host_resp_valid, host_resp_write, host_resp_rdata} !== {1'b1, 1'b1, 32'h0}) begin
      n_fail++; $display("FAIL stall_resp: got %b %b %h expected 1 1 0", host_resp_valid, host_resp_write, host_resp_rdata);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_bypass(input string name,
                             input logic i_en, input logic [3:0] i_a, input logic [31:0] i_d,
                             input logic c_en, input logic [3:0] c_a, input logic [31:0] c_d,
                             input logic [31:0] exp);
    drive_req(1'b0, 4'd7, 32'h0);
    core_write_enable = i_en; core_write_addr = i_a; core_write_data = i_d;
    @(posedge clk); #1;
    core_write_enable = c_en; core_write_addr = c_a; core_write_data = c_d;
    @(posedge clk); #1;
    core_write_enable = 1'b0;
    n_checks++; if ({host_resp_valid, host_resp_rdata} !== {1'b1, exp}) begin
      n_fail++; $display("FAIL bypass_%s: got %b %h expected 1 %h", name, host_resp_valid, host_resp_rdata, exp);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_resp_hold();
    int wr0;
    wr0 = host_wr_count;
    host_resp_ready = 1'b0;
    drive_req(1'b0, 4'd5, 32'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    host_req_valid = 1'b1; host_req_write = 1'b1; host_req_addr = 4'd3; host_req_wdata = 32'h5555_AAAA;
    for (int i = 0; i < 10; i++) begin
      n_checks++; if ({host_resp_valid, host_resp_rdata, host_req_ready} !== {1'b1, 32'h1234_5678, 1'b0}) begin
        n_fail++; $display("FAIL hold_cycle%0d: got %b %h ready %b expected 1 12345678 0", i, host_resp_valid, host_resp_rdata, host_req_ready);
      end
      @(posedge clk); #1;
    end
    host_req_valid = 1'b0;
    host_resp_ready = 1'b1;
    @(posedge clk); #1;
    n_checks++; if ({host_resp_valid, host_req_ready, dbg_state} !== {1'b0, 1'b1, 3'd0}) begin
      n_fail++; $display("FAIL hold_release: got %b %b %0d expected 0 1 0", host_resp_valid, host_req_ready, dbg_state);
    end
    n_checks++; if (host_wr_count !== wr0) begin n_fail++; $display("FAIL hold_no_accept: got %0d writes expected 0", host_wr_count - wr0); end
  endtask

  task automatic test_reset_mid_write();
    int wr0;
    wr0 = host_wr_count;
    drive_req(1'b1, 4'd4, 32'h0000_0077);
    core_write_enable = 1'b1; core_write_addr = 4'hB; core_write_data = 32'h0000_0001;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    n_checks++; if ({host_req_ready, rf_write_addr} !== {1'b0, 4'hB}) begin
      n_fail++; $display("FAIL rst_mid_pass: got ready %b addr %h expected 0 b", host_req_ready, rf_write_addr);
    end
    @(posedge clk); #1;
    n_checks++; if ({stall_count, host_resp_valid, dbg_state} !== {8'd0, 1'b0, 3'd0}) begin
      n_fail++; $display("FAIL rst_mid_clear: got stall %0d valid %b state %0d expected 0 0 0", stall_count, host_resp_valid, dbg_state);
    end
    reset = 1'b0;
    core_write_enable = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (host_req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_ready: got %b expected 1", host_req_ready); end
    for (int i = 0; i < 5; i++) begin
      n_checks++; if ({host_resp_valid, rf_write_enable} !== 2'b00) begin
        n_fail++; $display("FAIL rst_mid_quiet%0d: got valid %b we %b expected 0 0", i, host_resp_valid, rf_write_enable);
      end
      @(posedge clk); #1;
    end
    n_checks++; if (host_wr_count !== wr0) begin n_fail++; $display("FAIL rst_mid_no_write: got %0d writes expected 0", host_wr_count - wr0); end
  endtask

  initial begin
    n_checks = 0; n_fail = 0; host_wr_count = 0;
    reset = 1'b1;
    host_req_valid = 1'b0; host_req_write = 1'b0; host_req_addr = '0; host_req_wdata = '0;
    host_resp_ready = 1'b1;
    core_write_enable = 1'b0; core_write_addr = '0; core_write_data = '0;
    test_reset();
    test_write();
    test_read();
    test_stall();
    test_bypass("issue_hit",   1'b1, 4'd7, 32'hA5A5_A5A5, 1'b0, 4'd0, 32'h0,         32'hA5A5_A5A5);
    test_bypass("last_wins",   1'b1, 4'd7, 32'h1111_1111, 1'b1, 4'd7, 32'h2222_2222, 32'h2222_2222);
    test_bypass("miss",        1'b1, 4'd6, 32'h4444_4444, 1'b1, 4'd8, 32'h6666_6666, 32'hC0FF_EE07);
    test_bypass("capture_hit", 1'b0, 4'd7, 32'h0,         1'b1, 4'd7, 32'h3333_3333, 32'h3333_3333);
    test_resp_hold();
    test_reset_mid_write();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
